mac_layer_sched: RTL and testbench

//  Layer scheduler for one shared MAC neuron datapath (clear/enable accumulator, 16-bit acc).

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_out_hold.sv | 47 ++++
 rtl/mac_layer_sched.sv | 125 ++++++++++++
 tb/tb_mac_layer_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC layer scheduler.
package mac_pkg;

  localparam int unsigned ACC_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

endpackage

// File: rtl/mac_out_hold.sv
// Result capture register with valid/ready hold.
// Optional build macro: MAC_SCHED_RELU_EN clamps negative results to zero at capture.
module mac_out_hold #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [IDX_W-1:0] idx_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [ACC_W-1:0] out_data
);

  logic [ACC_W-1:0] cap_c;

  // Value presented at capture time.
  always_comb begin
`ifdef MAC_SCHED_RELU_EN
    cap_c = acc_in[ACC_W-1] ? '0 : acc_in;
`else
    cap_c = acc_in;
`endif
  end

  // Capture on load; hold data/index until the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx   <= idx_in;
      out_data  <= cap_c;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_layer_sched.sv
// Layer scheduler time-multiplexing one MAC across NUM_NEURONS neurons.
// Optional build macro: MAC_SCHED_RELU_EN (see mac_out_hold).
module mac_layer_sched
  import mac_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned ACC_W       = ACC_W_DEF,
  parameter int unsigned XA_W        = $clog2(NUM_INPUTS),
  parameter int unsigned WA_W        = $clog2(NUM_INPUTS * NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             rd_en,
  output logic [XA_W-1:0]  x_addr,
  output logic [WA_W-1:0]  w_addr,
  output logic             mac_clear,
  output logic             mac_en,
  input  logic [ACC_W-1:0] mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA_W-1:0]  out_idx,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             done
);

  sched_state_t     state, next_state;
  logic [XA_W-1:0]  i_q;
  logic [WA_W-1:0]  n_q;
  logic             drain_q;
  logic             i_last_c, n_last_c, accept_c, load_c;
  logic             rd_en_d, mac_clear_d, busy_d, done_d;
  logic [XA_W-1:0]  x_addr_d;
  logic [WA_W-1:0]  w_addr_d;

  assign i_last_c = (i_q == XA_W'(NUM_INPUTS - 1));
  assign n_last_c = (n_q == WA_W'(NUM_NEURONS - 1));
  assign accept_c = out_valid && out_ready;
  // Accumulator has settled by the first OUT cycle; capture it once.
  assign load_c   = (state == OUT) && !out_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CLEAR;
      CLEAR:   next_state = RUN;
      RUN:     if (i_last_c) next_state = DRAIN;
      DRAIN:   if (drain_q) next_state = OUT;
      OUT:     if (accept_c) next_state = n_last_c ? DONE : CLEAR;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Output decode, registered below.
  always_comb begin
    rd_en_d     = (state == RUN) && !abort;
    x_addr_d    = rd_en_d ? i_q : '0;
    w_addr_d    = rd_en_d ? (WA_W'(n_q * NUM_INPUTS) + WA_W'(i_q)) : '0;
    mac_clear_d = (state == CLEAR) && !abort;
    done_d      = (state == DONE) && !abort;
    busy_d      = (next_state != IDLE);
  end

  // Input index, neuron index and two-cycle drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= '0;
      n_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state == DRAIN) && !drain_q;
      if (state == CLEAR)            i_q <= '0;
      else if (state == RUN && !i_last_c) i_q <= i_q + XA_W'(1);
      if (state == IDLE)             n_q <= '0;
      else if (state == OUT && accept_c && !n_last_c) n_q <= n_q + WA_W'(1);
    end
  end

  // Registered strobes; mac_en trails rd_en by the buffer read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en     <= 1'b0;
      x_addr    <= '0;
      w_addr    <= '0;
      mac_clear <= 1'b0;
      mac_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en     <= rd_en_d;
      x_addr    <= x_addr_d;
      w_addr    <= w_addr_d;
      mac_clear <= mac_clear_d;
      mac_en    <= rd_en && !abort;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  mac_out_hold #(.ACC_W(ACC_W), .IDX_W(WA_W)) u_out_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .flush     (abort),
    .acc_in    (mac_acc),
    .idx_in    (n_q),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

endmodule

// File: tb/tb_mac_layer_sched.sv
// Directed bench for mac_layer_sched with a 1-cycle buffer and MAC model.
module tb_mac_layer_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic        rd_en, mac_clear, mac_en, out_valid, busy, done;
  logic [1:0]  x_addr;
  logic [2:0]  w_addr, out_idx;
  logic [15:0] mac_acc, out_data;

  logic [15:0] x_mem [4];
  logic [15:0] w_mem [8];
  logic [15:0] x_q, w_q;

  int checks = 0;
  int failures = 0;

  // Monitor results.
  int clear_first, clear_cnt, en_first, en_last0, en_cnt, rd_cnt;
  int valid_first, done_cnt, hold_viol, post_abort_act, res_n;
  logic busy_after_abort;
  bit timed_out;
  logic [2:0]  res_idx  [4];
  logic [15:0] res_data [4];

  always #5 clk = ~clk;

  mac_layer_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_en(rd_en), .x_addr(x_addr), .w_addr(w_addr),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  // Sync-read buffers.
  always @(posedge clk) begin
    if (rd_en) begin
      x_q <= x_mem[x_addr];
      w_q <= w_mem[w_addr];
    end
  end

  // MAC with clear/enable.
  always @(posedge clk or posedge rst) begin
    if (rst) mac_acc <= '0;
    else if (mac_clear) mac_acc <= '0;
    else if (mac_en) mac_acc <= mac_acc + x_q * w_q;
  end

  task automatic load_mem(input logic [15:0] x0, x1, x2, x3, w00, w01, w02, w03,
                          input logic [15:0] w10, w11, w12, w13);
    x_mem[0] = x0;  x_mem[1] = x1;  x_mem[2] = x2;  x_mem[3] = x3;
    w_mem[0] = w00; w_mem[1] = w01; w_mem[2] = w02; w_mem[3] = w03;
    w_mem[4] = w10; w_mem[5] = w11; w_mem[6] = w12; w_mem[7] = w13;
  endtask

  // Start a layer at edge 0, then observe at each negedge (cycle index).
  task automatic run_layer(input int stall, input bit busy_start, input int abort_at);
    int stall_left, idle_cnt;
    bit held;
    logic [15:0] hd;
    logic [2:0]  hi;
    clear_first = -1; clear_cnt = 0; en_first = -1; en_last0 = -1; en_cnt = 0;
    rd_cnt = 0; valid_first = -1; done_cnt = 0; hold_viol = 0; post_abort_act = 0;
    res_n = 0; busy_after_abort = 1'bx; stall_left = stall; held = 0; hd = '0; hi = '0;
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idle_cnt = 0;
    for (int cyc = 0; cyc < 200 && idle_cnt < 4; cyc++) begin
      @(negedge clk);
      abort = (cyc == abort_at);
      if (busy_start) start = (cyc == 4 || cyc == 9);
      if (mac_clear) begin clear_cnt++; if (clear_first < 0) clear_first = cyc; end
      if (mac_en) begin en_cnt++; if (en_first < 0) en_first = cyc; if (res_n == 0) en_last0 = cyc; end
      if (rd_en) rd_cnt++;
      if (abort_at >= 0 && cyc > abort_at && (rd_en || mac_en || out_valid)) post_abort_act++;
      if (cyc == abort_at + 1) busy_after_abort = busy;
      if (done) done_cnt++;
      if (out_valid) begin
        if (valid_first < 0) valid_first = cyc;
        if (rd_en || mac_en) hold_viol++;
        if (held && (out_data !== hd || out_idx !== hi)) hold_viol++;
        if (res_n == 0 && stall_left > 0) begin
          out_ready = 1'b0; stall_left--; held = 1; hd = out_data; hi = out_idx;
        end else begin
          out_ready = 1'b1; held = 0;
          if (res_n < 4) begin res_idx[res_n] = out_idx; res_data[res_n] = out_data; end
          res_n++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (!busy) idle_cnt++; else idle_cnt = 0;
    end
    timed_out = (idle_cnt < 4);
    abort = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({rd_en, mac_clear, mac_en, out_valid, busy, done} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b want=000000", {rd_en, mac_clear, mac_en, out_valid, busy, done}); end
    checks++; if ({x_addr, w_addr} !== 5'b0) begin
      failures++; $display("FAIL reset_addr got=%h want=0", {x_addr, w_addr}); end
    checks++; if (out_data !== 16'h0 || out_idx !== 3'h0) begin
      failures++; $display("FAIL reset_result got=%h/%h want=0/0", out_idx, out_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    load_mem(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_en !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL midrun_active got rd_en=%b busy=%b want 1/1", rd_en, busy); end
    rst = 1'b1; #1;
    checks++; if ({rd_en, mac_clear, mac_en, out_valid, busy, done, x_addr, w_addr} !== 11'b0) begin
      failures++; $display("FAIL midrun_reset got=%b want=0", {rd_en, mac_clear, mac_en, out_valid, busy, done, x_addr, w_addr}); end
    @(negedge clk); rst = 1'b0;
    run_layer(0, 0, -1);
    checks++; if (timed_out || res_n !== 2 || done_cnt !== 1) begin
      failures++; $display("FAIL after_reset_run got res=%0d done=%0d to=%0b want 2/1/0", res_n, done_cnt, timed_out); end
    checks++; if (res_data[0] !== 16'd10 || res_data[1] !== 16'd6) begin
      failures++; $display("FAIL after_reset_data got=%0d,%0d want=10,6", res_data[0], res_data[1]); end
  endtask

  task automatic test_basic_timing;
    load_mem(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
    run_layer(0, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
    checks++; if (clear_first !== 1 || clear_cnt !== 2) begin
      failures++; $display("FAIL clear_timing got first=%0d cnt=%0d want 1/2", clear_first, clear_cnt); end
    checks++; if (en_first !== 3 || en_last0 !== 6) begin
      failures++; $display("FAIL en_timing got %0d-%0d want 3-6", en_first, en_last0); end
    checks++; if (en_cnt !== 8 || rd_cnt !== 8) begin
      failures++; $display("FAIL en_count got en=%0d rd=%0d want 8/8", en_cnt, rd_cnt); end
    checks++; if (valid_first !== 8) begin
      failures++; $display("FAIL valid_latency got=%0d want=8", valid_first); end
    checks++; if (res_n !== 2 || res_idx[0] !== 3'd0 || res_data[0] !== 16'd10) begin
      failures++; $display("FAIL result0 got n=%0d idx=%0d data=%0d want 2/0/10", res_n, res_idx[0], res_data[0]); end
    checks++; if (res_idx[1] !== 3'd1 || res_data[1] !== 16'd6) begin
      failures++; $display("FAIL result1 got idx=%0d data=%0d want 1/6", res_idx[1], res_data[1]); end
    checks++; if (done_cnt !== 1) begin
      failures++; $display("FAIL done_once got=%0d want=1", done_cnt); end
  endtask

  task automatic test_stall;
    load_mem(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
    run_layer(5, 0, -1);
    checks++; if (timed_out || hold_viol !== 0) begin
      failures++; $display("FAIL stall_hold got viol=%0d to=%0b want 0/0", hold_viol, timed_out); end
    checks++; if (res_n !== 2 || res_data[0] !== 16'd10 || res_data[1] !== 16'd6 || res_idx[1] !== 3'd1) begin
      failures++; $display("FAIL stall_results got n=%0d %0d,%0d want 2 10,6", res_n, res_data[0], res_data[1]); end
    checks++; if (en_cnt !== 8 || done_cnt !== 1) begin
      failures++; $display("FAIL stall_counts got en=%0d done=%0d want 8/1", en_cnt, done_cnt); end
  endtask

  task automatic test_negative;
    logic [15:0] exp0;
`ifdef MAC_SCHED_RELU_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'hFFF4;
`endif
    load_mem(1, 1, 1, 1, 16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD, 2, 0, 0, 1);
    run_layer(0, 0, -1);
    checks++; if (timed_out || res_n !== 2 || res_data[0] !== exp0) begin
      failures++; $display("FAIL negative_result got=%h want=%h", res_data[0], exp0); end
    checks++; if (res_data[1] !== 16'd3) begin
      failures++; $display("FAIL negative_next got=%0d want=3", res_data[1]); end
  endtask

  task automatic test_abort;
    load_mem(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
    run_layer(0, 0, 11);
    checks++; if (timed_out || post_abort_act !== 0) begin
      failures++; $display("FAIL abort_quiet got act=%0d to=%0b want 0/0", post_abort_act, timed_out); end
    checks++; if (busy_after_abort !== 1'b0) begin
      failures++; $display("FAIL abort_idle got busy=%b want 0", busy_after_abort); end
    checks++; if (done_cnt !== 0 || res_n !== 1) begin
      failures++; $display("FAIL abort_no_done got done=%0d res=%0d want 0/1", done_cnt, res_n); end
  endtask

  task automatic test_start_while_busy;
    load_mem(1, 2, 3, 4, 1, 1, 1, 1, 2, 0, 0, 1);
    run_layer(0, 1, -1);
    checks++; if (timed_out || clear_cnt !== 2 || en_cnt !== 8 || done_cnt !== 1) begin
      failures++; $display("FAIL busy_start_counts got clr=%0d en=%0d done=%0d want 2/8/1", clear_cnt, en_cnt, done_cnt); end
    checks++; if (res_n !== 2 || res_data[0] !== 16'd10 || res_data[1] !== 16'd6) begin
      failures++; $display("FAIL busy_start_results got n=%0d %0d,%0d want 2 10,6", res_n, res_data[0], res_data[1]); end
  endtask

  task automatic test_abort_vs_start;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mac_clear !== 1'b0) begin
      failures++; $display("FAIL abort_wins got busy=%b clr=%b want 0/0", busy, mac_clear); end
  endtask

  initial begin
    test_reset;
    test_basic_timing;
    test_reset_mid_run;
    test_stall;
    test_negative;
    test_abort;
    test_start_while_busy;
    test_abort_vs_start;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
